// File: rtl/l2_writeback_buffer_pkg.sv
// Shared LC-3b types for the L2 writeback buffer.
// Tag width follows WB_OFFSET_BITS (16-byte lines by default).
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  localparam int WB_OFFSET_BITS = 4;

  typedef struct packed {
    logic                     valid;
    logic [15:WB_OFFSET_BITS] tag;
    lc3b_line                 data;
  } lc3b_wb_entry;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    RESP
  } lc3b_wb_state;

  function automatic logic [15:WB_OFFSET_BITS] line_tag(lc3b_word a);
    return a[15:WB_OFFSET_BITS];
  endfunction

endpackage

// File: rtl/l2_writeback_buffer_entry_array.sv
// Writeback entry storage: FIFO pointers plus youngest-match tag lookup.
// hit_data port only exists when WB_FWD_EN is defined.
module wb_entry_array
  import lc3b_types::*;
#(
  parameter int DEPTH       = 4,
  parameter int OFFSET_BITS = WB_OFFSET_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] push_addr,
  input  logic [127:0] push_data,
  input  logic [15:0] look_addr,
  output logic        hit,
`ifdef WB_FWD_EN
  output logic [127:0] hit_data,
`endif
  output logic [15:0] head_addr,
  output logic [127:0] head_data,
  output logic        empty,
  output logic        full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  lc3b_wb_entry    mem [DEPTH];
  logic [PW-1:0]   hd;
  logic [PW-1:0]   tl;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;

  assign count_nxt = count + CW'(push) - CW'(pop);
  assign full      = (count == CW'(DEPTH));
  assign head_addr = lc3b_word'(mem[hd].tag) << OFFSET_BITS;
  assign head_data = mem[hd].data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
      empty <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[tl] <= '{valid: 1'b1,
                     tag:   line_tag(push_addr),
                     data:  push_data};
        tl      <= tl + 1'b1;
      end
      if (pop) begin
        mem[hd].valid <= 1'b0;
        hd            <= hd + 1'b1;
      end
      count <= count_nxt;
      empty <= (count_nxt == '0);
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx = '0;
    hit = 1'b0;
`ifdef WB_FWD_EN
    hit_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = hd + PW'(i);
      if (mem[idx].valid &&
          mem[idx].tag == line_tag(look_addr)) begin
        hit = 1'b1;
`ifdef WB_FWD_EN
        hit_data = mem[idx].data;
`endif
      end
    end
  end

endmodule

// File: rtl/l2_writeback_buffer.sv
// Posted-write buffer between L2 and pmem; reads bypass queued writebacks.
// WB_FWD_EN: serve read hits from the buffer instead of draining first.
module l2_writeback_buffer
  import lc3b_types::*;
#(
  parameter int DEPTH       = 4,
  parameter int OFFSET_BITS = WB_OFFSET_BITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         l2_read,
  input  logic         l2_write,
  input  logic [15:0]  l2_address,
  input  logic [127:0] l2_wdata,
  output logic [127:0] l2_rdata,
  output logic         l2_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic         wb_empty
);

  lc3b_wb_state state;
  logic         push;
  logic         pop;
  logic         hit;
  logic         full;
  logic [15:0]  head_addr;
  logic [127:0] head_data;
`ifdef WB_FWD_EN
  logic [127:0] hit_data;
`endif

  assign push = (state == IDLE) && !l2_read && l2_write && !full;
  assign pop  = (state == DRAIN) && pmem_resp;

  wb_entry_array #(
    .DEPTH       (DEPTH),
    .OFFSET_BITS (OFFSET_BITS)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_addr (l2_address),
    .push_data (l2_wdata),
    .look_addr (l2_address),
    .hit       (hit),
`ifdef WB_FWD_EN
    .hit_data  (hit_data),
`endif
    .head_addr (head_addr),
    .head_data (head_data),
    .empty     (wb_empty),
    .full      (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      l2_resp      <= 1'b0;
      l2_rdata     <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (l2_read && hit) begin
`ifdef WB_FWD_EN
            l2_rdata <= hit_data;
            l2_resp  <= 1'b1;
            state    <= RESP;
`else
            // Older copy must reach pmem before the read goes out.
            pmem_write   <= 1'b1;
            pmem_address <= head_addr;
            pmem_wdata   <= head_data;
            state        <= DRAIN;
`endif
          end else if (l2_read) begin
            pmem_read    <= 1'b1;
            pmem_address <= l2_address;
            state        <= READ;
          end else if (push) begin
            l2_resp <= 1'b1;
            state   <= RESP;
          end else if (!wb_empty) begin
            pmem_write   <= 1'b1;
            pmem_address <= head_addr;
            pmem_wdata   <= head_data;
            state        <= DRAIN;
          end
        end
        READ: begin
          if (pmem_resp) begin
            pmem_read <= 1'b0;
            l2_rdata  <= pmem_rdata;
            l2_resp   <= 1'b1;
            state     <= RESP;
          end
        end
        DRAIN: begin
          if (pmem_resp) begin
            pmem_write <= 1'b0;
            state      <= IDLE;
          end
        end
        RESP: begin
          l2_resp <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Scoreboard bench for l2_writeback_buffer; coherent-memory reference model.
// Honours WB_FWD_EN in the same way as the design build.
module tb_l2_writeback_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         l2_read;
  logic         l2_write;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata;
  logic         l2_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         wb_empty;

  l2_writeback_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .l2_read      (l2_read),
    .l2_write     (l2_write),
    .l2_address   (l2_address),
    .l2_wdata     (l2_wdata),
    .l2_rdata     (l2_rdata),
    .l2_resp      (l2_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .wb_empty     (wb_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           rd;
    logic [127:0] data;
  } exp_t;

  typedef struct {
    logic [15:0]  a;
    logic [127:0] d;
  } wr_t;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t         exp_resp [$];
  wr_t          exp_wr   [$];
  int           req_log  [$];
  logic [127:0] mem_m    [logic [15:0]];
  logic [127:0] shadow   [logic [15:0]];

  bit           stall   = 1'b0;
  int           max_lat = 0;

  task automatic chk(string n, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  function automatic logic [127:0] init_line(logic [15:0] a);
    return {8{a}} ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  endfunction

  function automatic logic [127:0] mem_get(logic [15:0] a);
    logic [15:0] l;
    l = a & 16'hfff0;
    return mem_m.exists(l) ? mem_m[l] : init_line(l);
  endfunction

  function automatic logic [127:0] shadow_get(logic [15:0] a);
    logic [15:0] l;
    l = a & 16'hfff0;
    return shadow.exists(l) ? shadow[l] : init_line(l);
  endfunction

  // Issue one L2 request at posedge+1; returns cycles to l2_resp.
  task automatic l2_op(input bit rd, input logic [15:0] a,
                       input logic [127:0] d, output int lat);
    exp_t e;
    wr_t  w;
    e.rd   = rd;
    e.data = '0;
    if (rd) begin
      e.data = shadow_get(a);
    end else begin
      shadow[a & 16'hfff0] = d;
      w.a = a;
      w.d = d;
      exp_wr.push_back(w);
    end
    exp_resp.push_back(e);
    l2_read    = rd;
    l2_write   = !rd;
    l2_address = a;
    l2_wdata   = rd ? {4{$urandom}} : d;
    lat = 0;
    while (lat < 300) begin
      @(negedge clk);
      if (l2_resp) break;
      lat++;
    end
    if (lat >= 300) chk("l2_timeout", 1, 0);
    @(posedge clk);
    #1;
    l2_read  = 1'b0;
    l2_write = 1'b0;
  endtask

  task automatic wait_empty();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wb_empty && !pmem_write && !pmem_read) break;
    end
    if (i >= 300) chk("drain_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for l2 responses.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && l2_resp) begin
      if (exp_resp.size() == 0) begin
        chk("l2_resp_unexpected", 1, 0);
      end else begin
        mon_e = exp_resp.pop_front();
        if (mon_e.rd) chk("l2_rdata", l2_rdata, mon_e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(l2_read && l2_write))
        else $error("FAIL l2_read and l2_write together");
      if (pmem_read && pmem_write) chk("pmem_excl", 1, 0);
    end
  end

  // pmem model: random latency, checks write order against the FIFO model.
  bit           busy = 1'b0;
  int           wait_cnt = 0;
  logic [15:0]  lat_addr;
  logic [127:0] lat_data;
  wr_t          rsp_w;
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else if (pmem_read || pmem_write) begin
        if (!busy) begin
          busy     = 1'b1;
          wait_cnt = $urandom_range(0, max_lat);
          lat_addr = pmem_address;
          lat_data = pmem_wdata;
          req_log.push_back(pmem_write ? 1 : 0);
        end
        if (!stall) begin
          if (wait_cnt > 0) begin
            wait_cnt--;
          end else begin
            chk("pmem_stable", 128'(pmem_address == lat_addr &&
                                    pmem_wdata == lat_data), 1);
            if (pmem_write) begin
              if (exp_wr.size() == 0) begin
                chk("pmem_wr_unexpected", 1, 0);
              end else begin
                rsp_w = exp_wr.pop_front();
                chk("pmem_wr_addr", 128'(pmem_address), 128'(rsp_w.a));
                chk("pmem_wr_data", pmem_wdata, rsp_w.d);
              end
              mem_m[pmem_address & 16'hfff0] = pmem_wdata;
            end else begin
              pmem_rdata = mem_get(pmem_address);
            end
            pmem_resp = 1'b1;
            busy      = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int          lat;
    int          gap;
    bit          rd;
    logic [15:0] a;
    logic [127:0] b;
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_address = '0;
    l2_wdata   = '0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_l2_resp", 128'(l2_resp), 0);
    chk("rst_pmem_rw", 128'({pmem_read, pmem_write}), 0);
    chk("rst_pmem_addr", 128'(pmem_address), 0);
    chk("rst_wb_empty", 128'(wb_empty), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write: ack at cycle 1, then drains.
    l2_op(0, 16'h1230, 128'hAAAA_0000_1111_2222_3333_4444_5555_6666, lat);
    chk("wr_ack_lat", 128'(lat), 1);
    repeat (10) @(negedge clk);
    chk("wr_drained_empty", 128'(wb_empty), 1);
    @(posedge clk);
    #1;

    // Fill the buffer with pmem stalled, fifth write must wait.
    stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      l2_op(0, 16'(i) << 12, {4{32'(i) * 32'h1010_1010}}, lat);
      chk("fill_ack_lat", 128'(lat), 1);
    end
    fork
      begin
        repeat (15) @(posedge clk);
        #2;
        stall = 1'b0;
      end
    join_none
    l2_op(0, 16'h5000, {4{32'h5555_aaaa}}, lat);
    chk("full_write_blocked", 128'(lat >= 15), 1);
    wait_empty();

    // Read miss bypasses a queued writeback.
    req_log.delete();
    l2_op(0, 16'h2000, {4{32'h2000_b0b0}}, lat);
    fork
      l2_op(1, 16'h8000, '0, lat);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("miss_pmem_read_c1", 128'(pmem_read), 1);
      end
    join
    chk("read_before_write",
        128'(req_log.size() > 0 ? req_log[0] : 2), 0);
    wait_empty();

    // Read hitting a buffered line at a non-zero offset.
    req_log.delete();
    b = {4{32'hbbbb_0002}};
    l2_op(0, 16'h2000, b, lat);
    l2_op(1, 16'h2004, '0, lat);
`ifdef WB_FWD_EN
    chk("fwd_lat", 128'(lat), 1);
    chk("fwd_no_pmem", 128'(req_log.size()), 0);
`else
    chk("drain_then_read_n", 128'(req_log.size() >= 2), 1);
    chk("drain_then_read",
        128'(req_log.size() >= 2 ? {req_log[0][0], req_log[1][0]} : 2'b11),
        128'(2'b10));
`endif
    wait_empty();

    // Duplicate lines: youngest wins, both reach pmem in order.
    l2_op(0, 16'h3000, {4{32'hc0c0_c0c0}}, lat);
    l2_op(0, 16'h3000, {4{32'hd0d0_d0d0}}, lat);
    l2_op(1, 16'h3000, '0, lat);
    wait_empty();

    // Randomised traffic with random pmem latency.
    max_lat = 3;
    for (int i = 0; i < 80; i++) begin
      rd = 1'($urandom_range(0, 1));
      a  = 16'h4000 + (16'($urandom_range(0, 5)) << 4);
      if (rd) a = a | 16'($urandom_range(0, 15));
      l2_op(rd, a, {$urandom, $urandom, $urandom, $urandom}, lat);
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    wait_empty();
    chk("wr_queue_empty", 128'(exp_wr.size()), 0);
    chk("resp_queue_empty", 128'(exp_resp.size()), 0);

    // Reset in the middle of a drain.
    max_lat = 0;
    stall = 1'b1;
    l2_op(0, 16'h6000, {4{32'h6666_0606}}, lat);
    lat = 0;
    while (!pmem_write && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("drain_started", 128'(pmem_write), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pmem_rw", 128'({pmem_read, pmem_write}), 0);
    chk("mid_rst_l2_resp", 128'(l2_resp), 0);
    chk("mid_rst_addr", 128'(pmem_address), 0);
    chk("mid_rst_wb_empty", 128'(wb_empty), 1);
    exp_wr.delete();
    shadow = mem_m;
    stall  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 128'({pmem_read, pmem_write, l2_resp, wb_empty}),
        128'(4'b0001));
    @(posedge clk);
    #1;
    l2_op(1, 16'h6000, '0, lat);
    wait_empty();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
